// File: rtl/lvds_tx_framer.sv
// lvds_tx_framer: FIFO-buffered word framer with link bring-up for the LVDS serializer
module lvds_tx_framer #(
    parameter int WORD_W = 32,
    parameter int BEAT_W = 8,
    parameter int DEPTH = 4,
    parameter logic [BEAT_W-1:0] TRAIN_PAT = 'h6A,
    parameter logic [BEAT_W-1:0] SYNC_PAT = 'hA5,
    parameter logic [BEAT_W-1:0] MARK_PAT = 'h77,
    parameter logic [BEAT_W-1:0] IDLE_PAT = 'h52
) (
    input  logic inclock,
    input  logic reset_n,
    input  logic tx_locked,
    input  logic tx_align_done,
    input  logic [WORD_W-1:0] enq_tx_put,
    input  logic EN_enq_tx_put,
    output logic RDY_enq_tx_put,
    output logic [BEAT_W-1:0] tx_in,
    output logic link_up,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic drop_err
);
    localparam int NBEATS = WORD_W / BEAT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(NBEATS);
    localparam logic [IW-1:0] LAST = IW'(NBEATS - 1);
    typedef enum logic [2:0] {WAIT_LOCK, TRAIN, SYNC, IDLE, MARK, DATA} state_t;
    state_t state;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] shreg, head;
    logic [AW-1:0] wp, rp;
    logic [IW-1:0] idx;
    logic [CW-1:0] count_n;
    logic enq, pop, pending;
    assign enq = EN_enq_tx_put & RDY_enq_tx_put;
    assign pop = state == MARK;
    assign head = mem[rp];
    assign pending = fifo_count != '0;
    assign count_n = fifo_count + CW'(enq) - CW'(pop);
    always_ff @(posedge inclock)
        if (enq) mem[wp] <= enq_tx_put;
    always_ff @(posedge inclock) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
            RDY_enq_tx_put <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            if (enq) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            fifo_count <= count_n;
            RDY_enq_tx_put <= count_n < CW'(DEPTH);
            drop_err <= drop_err | (EN_enq_tx_put & ~RDY_enq_tx_put);
        end
    end
    // a word popped in MARK is lost if lock drops; the FIFO keeps the rest
    always_ff @(posedge inclock) begin
        if (!reset_n) begin
            state <= WAIT_LOCK;
            tx_in <= '0;
            link_up <= 1'b0;
            idx <= '0;
            shreg <= '0;
        end else if (!tx_locked && state != WAIT_LOCK) begin
            state <= WAIT_LOCK;
            tx_in <= '0;
            link_up <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: if (tx_locked) begin
                    state <= TRAIN;
                    tx_in <= TRAIN_PAT;
                end
                TRAIN: if (tx_align_done) begin
                    state <= SYNC;
                    tx_in <= SYNC_PAT;
                end
                SYNC: begin
                    state <= IDLE;
                    tx_in <= IDLE_PAT;
                    link_up <= 1'b1;
                end
                IDLE: if (pending) begin
                    state <= MARK;
                    tx_in <= MARK_PAT;
                end
                MARK: begin
                    state <= DATA;
                    idx <= '0;
                    tx_in <= head[WORD_W-1 -: BEAT_W];
                    shreg <= head << BEAT_W;
                end
                DATA: if (idx == LAST) begin
                    state <= pending ? MARK : IDLE;
                    tx_in <= pending ? MARK_PAT : IDLE_PAT;
                end else begin
                    idx <= idx + IW'(1);
                    tx_in <= shreg[WORD_W-1 -: BEAT_W];
                    shreg <= shreg << BEAT_W;
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end
endmodule

// File: tb/tb_lvds_tx_framer.sv
// tb_lvds_tx_framer: scoreboard bench for lvds_tx_framer (default build plus a 64/16/8 build)
module tb_lvds_tx_framer;
    localparam int DEPTH = 4;
    localparam int NB = 4;
    localparam logic [7:0] TRAIN = 8'h6A, SYNC = 8'hA5, MARK = 8'h77, IDLE = 8'h52;
    logic inclock = 0, reset_n = 0, tx_locked = 0, tx_align_done = 0, en = 0;
    logic [31:0] data = '0;
    logic rdy, link_up, drop_err;
    logic [7:0] tx_in;
    logic [2:0] fifo_count;
    logic reset2_n = 0, locked2 = 0, align2 = 0, en2 = 0;
    logic [63:0] data2 = '0;
    logic rdy2, up2, drop2;
    logic [15:0] tx2;
    logic [3:0] cnt2;
    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic mrdy = 0, mdrop = 0, mvalid = 0, done2 = 0;

    always #5 inclock = ~inclock;

    lvds_tx_framer dut (
        .inclock(inclock), .reset_n(reset_n), .tx_locked(tx_locked), .tx_align_done(tx_align_done),
        .enq_tx_put(data), .EN_enq_tx_put(en), .RDY_enq_tx_put(rdy), .tx_in(tx_in),
        .link_up(link_up), .fifo_count(fifo_count), .drop_err(drop_err)
    );

    lvds_tx_framer #(.WORD_W(64), .BEAT_W(16), .DEPTH(8)) dut2 (
        .inclock(inclock), .reset_n(reset2_n), .tx_locked(locked2), .tx_align_done(align2),
        .enq_tx_put(data2), .EN_enq_tx_put(en2), .RDY_enq_tx_put(rdy2), .tx_in(tx2),
        .link_up(up2), .fifo_count(cnt2), .drop_err(drop2)
    );

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    task automatic tick();
        @(posedge inclock);
        #1;
    endtask

    task automatic enq(input logic [31:0] w);
        en = 1;
        data = w;
        tick();
        en = 0;
    endtask

    task automatic wait_link();
        for (int i = 0; i < 100 && !link_up; i++) tick();
        chk("link_up_timeout", 64'(link_up), 64'(1));
    endtask

    // reference FIFO: accepted words queue up; the monitor removes one per marker
    initial forever begin
        @(posedge inclock);
        if (!reset_n) begin
            exp_q.delete();
            mrdy = 0;
            mdrop = 0;
            mvalid = 1;
        end else begin
            if (en && !mrdy) mdrop = 1;
            if (en && mrdy) exp_q.push_back(data);
            mrdy = exp_q.size() < DEPTH;
        end
    end

    initial begin
        int left = 0;
        logic [31:0] cur = '0;
        logic prev_up = 0, prev_pend = 0;
        logic [7:0] want;
        forever begin
            @(negedge inclock);
            if (mvalid) begin
                chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
                chk("rdy", 64'(rdy), 64'(mrdy));
                chk("drop_err", 64'(drop_err), 64'(mdrop));
                if (!link_up) begin
                    left = 0;
                    chk("down_beat", 64'(tx_in == 8'h00 || tx_in == TRAIN || tx_in == SYNC), 64'(1));
                end else if (left > 0) begin
                    chk("data_beat", 64'(tx_in), 64'(cur[31:24]));
                    cur = cur << 8;
                    left--;
                end else begin
                    want = (prev_up && prev_pend) ? MARK : IDLE;
                    chk("frame_start", 64'(tx_in), 64'(want));
                    if (want == MARK) begin
                        cur = exp_q.pop_front();
                        left = NB;
                    end
                end
                prev_up = link_up;
                prev_pend = exp_q.size() != 0;
            end
        end
    end

    initial begin
        logic [7:0] s1 [6] = '{8'h77, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h52};
        logic [7:0] s2 [12] = '{8'h52, 8'h77, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'h77, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h52};
        logic [7:0] s3 [7] = '{8'h52, 8'h77, 8'h11, 8'h22, 8'h33, 8'h44, 8'h52};
        logic [7:0] e;
        tick();
        tick();
        chk("rst_tx", 64'(tx_in), 64'(0));
        chk("rst_rdy", 64'(rdy), 64'(0));
        chk("rst_link", 64'(link_up), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_drop", 64'(drop_err), 64'(0));
        reset_n = 1;
        tick();
        chk("rdy_after_rst", 64'(rdy), 64'(1));
        for (int c = 1; c <= 24; c++) begin
            tx_locked = c >= 5;
            tx_align_done = c >= 20;
            tick();
            e = c < 5 ? 8'h00 : c < 20 ? TRAIN : c == 20 ? SYNC : IDLE;
            chk("bringup_tx", 64'(tx_in), 64'(e));
            chk("bringup_link", 64'(link_up), 64'(c >= 21));
        end
        enq(32'hDEADBEEF);
        chk("single_count", 64'(fifo_count), 64'(1));
        chk("single_pre", 64'(tx_in), 64'(IDLE));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("single_seq", 64'(tx_in), 64'(s1[i]));
        end
        // pops every NB+1 cycles, so five back-to-back words fit and the sixth is dropped
        for (int i = 0; i < 6; i++) begin
            en = 1;
            data = $urandom;
            tick();
            if (i == 3) chk("full_rdy_before", 64'(rdy), 64'(1));
            if (i == 4) chk("full_rdy_low", 64'(rdy), 64'(0));
            if (i == 4) chk("full_count", 64'(fifo_count), 64'(DEPTH));
            if (i == 5) chk("full_drop", 64'(drop_err), 64'(1));
        end
        en = 0;
        for (int i = 0; i < 100 && fifo_count != 0; i++) tick();
        chk("full_drain", 64'(fifo_count), 64'(0));
        repeat (NB + 2) tick();
        reset_n = 0;
        tx_locked = 0;
        tx_align_done = 0;
        tick();
        tick();
        chk("rst2_drop", 64'(drop_err), 64'(0));
        reset_n = 1;
        tick();
        tx_locked = 1;
        tick();
        enq(32'h01020304);
        enq(32'hA0B0C0D0);
        chk("train_count", 64'(fifo_count), 64'(2));
        chk("train_tx", 64'(tx_in), 64'(TRAIN));
        tx_align_done = 1;
        wait_link();
        chk("train_seq", 64'(tx_in), 64'(s2[0]));
        for (int i = 1; i < 12; i++) begin
            tick();
            chk("train_seq", 64'(tx_in), 64'(s2[i]));
        end
        enq(32'hDEADBEEF);
        enq(32'h11223344);
        tick();
        chk("loss_de", 64'(tx_in), 64'(8'hDE));
        tx_locked = 0;
        tick();
        chk("loss_tx", 64'(tx_in), 64'(0));
        chk("loss_link", 64'(link_up), 64'(0));
        chk("loss_count", 64'(fifo_count), 64'(1));
        tick();
        tick();
        tx_locked = 1;
        wait_link();
        chk("relock_seq", 64'(tx_in), 64'(s3[0]));
        for (int i = 1; i < 7; i++) begin
            tick();
            chk("relock_seq", 64'(tx_in), 64'(s3[i]));
        end
        for (int i = 0; i < 600; i++) begin
            en = 1'($urandom_range(0, 1));
            data = $urandom;
            tx_align_done = $urandom_range(0, 3) == 0;
            if (tx_locked && $urandom_range(0, 49) == 0) tx_locked = 0;
            else if (!tx_locked && $urandom_range(0, 2) == 0) tx_locked = 1;
            tick();
        end
        en = 0;
        tx_locked = 1;
        tx_align_done = 1;
        for (int i = 0; i < 200 && (fifo_count != 0 || !link_up); i++) tick();
        chk("final_drain", 64'(fifo_count), 64'(0));
        repeat (NB + 2) tick();
        for (int i = 0; i < 1000 && !done2; i++) tick();
        chk("dut2_done", 64'(done2), 64'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [15:0] w2 [6] = '{16'h0077, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0052};
        tick();
        tick();
        reset2_n = 1;
        locked2 = 1;
        align2 = 1;
        for (int i = 0; i < 20 && !up2; i++) tick();
        chk("d2_link", 64'(up2), 64'(1));
        chk("d2_idle", 64'(tx2), 64'(16'h0052));
        en2 = 1;
        data2 = 64'h0123456789ABCDEF;
        tick();
        en2 = 0;
        chk("d2_count1", 64'(cnt2), 64'(1));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("d2_seq", 64'(tx2), 64'(w2[i]));
        end
        locked2 = 0;
        tick();
        tick();
        chk("d2_down", 64'(up2), 64'(0));
        for (int k = 1; k <= 8; k++) begin
            en2 = 1;
            data2 = {$urandom, $urandom};
            tick();
            chk("d2_fill_count", 64'(cnt2), 64'(k));
            chk("d2_fill_rdy", 64'(rdy2), 64'(k < 8));
        end
        en2 = 0;
        chk("d2_nodrop", 64'(drop2), 64'(0));
        done2 = 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
